// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator and the bounce LFSR.
// Key code layout is [3:2] row index, [1:0] column index.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam int                  LFSR_W       = 8;
  // Right-shifting Galois mask for x^8+x^6+x^5+x^4+1
  localparam logic [LFSR_W-1:0]   LFSR_TAPS    = 8'hB8;
  localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 8'hA5;

  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[KEY_ROW_MSB:KEY_ROW_LSB];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[KEY_COL_MSB:KEY_COL_LSB];
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 8-bit Galois LFSR used as the contact-bounce noise source.
// Advances every cycle; reset loads SEED.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  if (SEED == '0) begin : g_seed_check
    $error("bounce_lfsr: SEED must be non-zero");
  end

  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= SEED;
    end else begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/keypad_emulator.sv
// Device-side 4x4 keypad model: plays a requested key press with LFSR bounce,
// hold and release gap, pulling the selected row low when its column is driven.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int                BOUNCE_CYCLES = 4,
  parameter int                HOLD_CYCLES   = 20,
  parameter int                GAP_CYCLES    = 10,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  output logic       busy,
  output logic       done
);

  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("keypad_emulator: HOLD_CYCLES must be >= 1");
  end
  if (LFSR_SEED == '0) begin : g_seed_check
    $error("keypad_emulator: LFSR_SEED must be non-zero");
  end

  localparam int MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_LEN = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  localparam logic [CW-1:0] LD_B = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LD_H = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_G = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [3:0]        r_key, w_key_next;
  logic              r_contact, w_contact_next;
  logic              r_done, w_done_next;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_phase_end;
  logic              w_unused_lfsr;

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Only bit 0 drives the contact; the rest is the LFSR's internal state.
  assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:1];
  assign w_phase_end   = (r_cnt == '0);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_key_next     = r_key;
    w_done_next    = 1'b0;
    w_contact_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (press_valid) begin
          w_key_next = press_key;
          if (BOUNCE_CYCLES > 0) begin
            w_state_next = S_BOUNCE_IN;
            w_cnt_next   = LD_B;
          end else begin
            w_state_next = S_HOLD;
            w_cnt_next   = LD_H;
          end
        end
      end
      S_BOUNCE_IN: begin
        if (w_phase_end) begin
          w_state_next = S_HOLD;
          w_cnt_next   = LD_H;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (!w_phase_end) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (BOUNCE_CYCLES > 0) begin
          w_state_next = S_BOUNCE_OUT;
          w_cnt_next   = LD_B;
        end else if (GAP_CYCLES > 0) begin
          w_state_next = S_GAP;
          w_cnt_next   = LD_G;
        end else begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      S_BOUNCE_OUT: begin
        if (!w_phase_end) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (GAP_CYCLES > 0) begin
          w_state_next = S_GAP;
          w_cnt_next   = LD_G;
        end else begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_phase_end) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Contact is registered from the state being entered, so it is glitch-free.
    case (w_state_next)
      S_HOLD:                    w_contact_next = 1'b1;
      S_BOUNCE_IN, S_BOUNCE_OUT: w_contact_next = w_lfsr[0];
      default:                   w_contact_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_key     <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_key     <= w_key_next;
      r_contact <= w_contact_next;
      r_done    <= w_done_next;
    end
  end

  // Combinational column-to-row path, like a physical switch matrix.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row[gi] = ~(r_contact && (key_row(r_key) == 2'(gi)) && !col[key_col(r_key)]);
  end

  assign press_ready = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: per-cycle expected row/handshake
// values are queued when a press is issued and compared as the press plays out.
module tb_keypad_emulator;

  localparam int TB_B = 4;
  localparam int TB_H = 20;
  localparam int TB_G = 10;
  localparam int LAT  = 2 * TB_B + TB_H + TB_G + 1;
  localparam int NB_H = 20;
  localparam int NB_G = 10;

  typedef struct packed {
    logic [3:0] row;
    logic       ready;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [3:0] col, row, press_key;
  logic       press_valid, press_ready, busy, done;
  logic [3:0] nb_col, nb_row, nb_key;
  logic       nb_valid, nb_ready, nb_busy, nb_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_lfsr;
  obs_t       exp_q[$];
  obs_t       nb_q[$];

  keypad_emulator dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .press_valid (press_valid),
    .press_key   (press_key),
    .press_ready (press_ready),
    .busy        (busy),
    .done        (done)
  );

  keypad_emulator #(.BOUNCE_CYCLES(0)) dut_nb (
    .clk         (clk),
    .rst         (rst),
    .col         (nb_col),
    .row         (nb_row),
    .press_valid (nb_valid),
    .press_key   (nb_key),
    .press_ready (nb_ready),
    .busy        (nb_busy),
    .done        (nb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_step(input logic [7:0] v);
    logic [7:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 8'b1011_1000;
    return n;
  endfunction

  // Reference LFSR value for the current cycle.
  always @(posedge clk) m_lfsr <= rst ? 8'hA5 : tb_step(m_lfsr);

  function automatic obs_t exp_obs(input logic [3:0] key, input logic [3:0] colv,
                                   input logic contact, input logic ready, input logic dn);
    obs_t       o;
    logic [1:0] ci;
    logic [1:0] ri;
    ci      = key[1:0];
    ri      = key[3:2];
    o.row   = 4'hF;
    if (contact && colv[ci] == 1'b0) o.row[ri] = 1'b0;
    o.ready = ready;
    o.busy  = !ready;
    o.done  = dn;
    return o;
  endfunction

  // Expected cycles 1..LAT after an accept whose cycle had LFSR value l0.
  task automatic push_press(input logic [3:0] key, input logic [3:0] colv,
                            input logic [7:0] l0, input bit tail);
    logic [7:0] lv;
    logic       c;
    lv = l0;
    for (int n = 1; n <= LAT; n++) begin
      if (n <= TB_B || (n > TB_B + TB_H && n <= 2 * TB_B + TB_H)) c = lv[0];
      else c = (n > TB_B && n <= TB_B + TB_H);
      exp_q.push_back(exp_obs(key, colv, c, n == LAT, n == LAT));
      lv = tb_step(lv);
    end
    if (tail) exp_q.push_back(exp_obs(key, colv, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic test_reset();
    obs_t a, a2;
    rst = 1'b1; col = 4'b0000; press_valid = 1'b1; press_key = 4'h5;
    nb_col = 4'b0000; nb_valid = 1'b1; nb_key = 4'h5;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      a  = obs_t'({row, press_ready, busy, done});
      a2 = obs_t'({nb_row, nb_ready, nb_busy, nb_done});
      checks++;
      if (a !== obs_t'(7'b1111_000)) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b want=%b", i, a, 7'b1111_000);
      end
      checks++;
      if (a2 !== obs_t'(7'b1111_000)) begin
        failures++;
        $display("FAIL reset_nb cyc=%0d got=%b want=%b", i, a2, 7'b1111_000);
      end
    end
    rst = 1'b0; press_valid = 1'b0; nb_valid = 1'b0;
    @(negedge clk);
    a = obs_t'({row, press_ready, busy, done});
    checks++;
    if (a !== obs_t'(7'b1111_100)) begin
      failures++;
      $display("FAIL reset_release got=%b want=%b", a, 7'b1111_100);
    end
    $display("reset: done");
  endtask

  task automatic test_decode();
    logic [3:0] pat [4];
    obs_t       e, a;
    int         nxt;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    nb_key = 4'b0110; nb_valid = 1'b1; nb_col = pat[0];
    checks++;
    if (nb_ready !== 1'b1) begin
      failures++;
      $display("FAIL decode_ready got=%b want=1", nb_ready);
    end
    nb_q.push_back(exp_obs(4'b0110, pat[0], 1'b1, 1'b0, 1'b0));
    for (int n = 1; n <= NB_H + NB_G + 2; n++) begin
      @(negedge clk);
      nb_valid = 1'b0;
      a = obs_t'({nb_row, nb_ready, nb_busy, nb_done});
      checks++;
      if (nb_q.size() == 0) begin
        failures++;
        $display("FAIL decode cyc=%0d scoreboard empty got=%b", n, a);
      end else begin
        e = nb_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL decode cyc=%0d col=%b got=%b want=%b", n, nb_col, a, e);
        end
      end
      nb_col = pat[n % 4];
      nxt = n + 1;
      nb_q.push_back(exp_obs(4'b0110, nb_col, nxt <= NB_H,
                             nxt >= NB_H + NB_G + 1, nxt == NB_H + NB_G + 1));
    end
    nb_q.delete();
    $display("decode: done");
  endtask

  task automatic test_press(input string name, input logic [3:0] key, input logic [3:0] colv);
    obs_t e, a;
    col = colv; press_key = key; press_valid = 1'b1;
    checks++;
    if (press_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept_ready got=%b want=1", name, press_ready);
    end
    push_press(key, colv, m_lfsr, 1'b1);
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      press_valid = 1'b0;
      a = obs_t'({row, press_ready, busy, done});
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s cyc=%0d scoreboard empty got=%b", name, n, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%b want=%b", name, n, a, e);
        end
      end
    end
    $display("%s: key=%h col=%b done", name, key, colv);
  endtask

  task automatic test_back_to_back();
    obs_t       e, a;
    logic [7:0] l39;
    col = 4'b0110; press_key = 4'h3; press_valid = 1'b1;
    checks++;
    if (press_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b accept_ready got=%b want=1", press_ready);
    end
    l39 = m_lfsr;
    for (int i = 0; i < LAT; i++) l39 = tb_step(l39);
    push_press(4'h3, 4'b0110, m_lfsr, 1'b0);
    push_press(4'hC, 4'b0110, l39, 1'b1);
    for (int n = 1; n <= 2 * LAT + 1; n++) begin
      @(negedge clk);
      a = obs_t'({row, press_ready, busy, done});
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b cyc=%0d scoreboard empty got=%b", n, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL b2b cyc=%0d got=%b want=%b", n, a, e);
        end
      end
      if (n == 5) press_key = 4'hC;
      if (n == LAT + 1) press_valid = 1'b0;
    end
    $display("back_to_back: done");
  endtask

  task automatic test_abort();
    obs_t e, a;
    col = 4'b1011; press_key = 4'b0110; press_valid = 1'b1;
    push_press(4'b0110, 4'b1011, m_lfsr, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      press_valid = 1'b0;
      a = obs_t'({row, press_ready, busy, done});
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%b want=%b", n, a, e);
      end
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    a = obs_t'({row, press_ready, busy, done});
    checks++;
    if (a !== obs_t'(7'b1111_000)) begin
      failures++;
      $display("FAIL abort_reset cyc=13 got=%b want=%b", a, 7'b1111_000);
    end
    rst = 1'b0;
    @(negedge clk);
    a = obs_t'({row, press_ready, busy, done});
    checks++;
    if (a !== obs_t'(7'b1111_100)) begin
      failures++;
      $display("FAIL abort_idle cyc=14 got=%b want=%b", a, 7'b1111_100);
    end
    $display("abort: done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_press("latency", 4'hF, 4'b0111);
    test_press("bounce", 4'b0110, 4'b1011);
    test_press("multicol", 4'h9, 4'b0000);
    test_press("nomatch", 4'h0, 4'b1101);
    test_back_to_back();
    test_abort();
    test_press("after_abort", 4'b0110, 4'b1011);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
